// File: rtl/mul_pkg.sv
// Shared types and op decode helpers for the iterative multiply / multiply-accumulate unit.
package mul_pkg;

    typedef enum logic [2:0] {
        MUL_OP_MUL   = 3'b000,
        MUL_OP_MLA   = 3'b001,
        MUL_OP_RSV2  = 3'b010,
        MUL_OP_RSV3  = 3'b011,
        MUL_OP_UMULL = 3'b100,
        MUL_OP_UMLAL = 3'b101,
        MUL_OP_SMULL = 3'b110,
        MUL_OP_SMLAL = 3'b111
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_long(input mul_op_e op);
        return op inside {MUL_OP_UMULL, MUL_OP_UMLAL, MUL_OP_SMULL, MUL_OP_SMLAL};
    endfunction

    function automatic logic is_signed(input mul_op_e op);
        return op inside {MUL_OP_SMULL, MUL_OP_SMLAL};
    endfunction

    function automatic logic is_acc(input mul_op_e op);
        return op inside {MUL_OP_MLA, MUL_OP_UMLAL, MUL_OP_SMLAL};
    endfunction

    function automatic logic is_valid_op(input mul_op_e op);
        return !(op inside {MUL_OP_RSV2, MUL_OP_RSV3});
    endfunction

endpackage

// File: rtl/mul_unit_step.sv
// One multiply iteration: adds the pre-shifted multiplicand times a BITS_PER_CYCLE-bit
// multiplier digit into the running 2*WIDTH partial sum.
module mul_unit_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        i_psum,
    input  logic [2*WIDTH-1:0]        i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_mbits,
    output logic [2*WIDTH-1:0]        o_psum
);

    always_comb begin
        o_psum = i_psum;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (i_mbits[i]) begin
                o_psum = o_psum + (i_mcand << i);
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit with valid/ready on both sides.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier is zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [3:0]       flags_out,
    output logic             flags_we
);

    localparam int W2    = 2 * WIDTH;
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    mul_state_e       r_state, w_next_state;
    mul_op_e          r_op, w_op_in;
    logic             r_s_bit, r_neg;
    logic [W2-1:0]    r_mcand, r_psum, w_psum_next, w_prod;
    logic [WIDTH-1:0] r_mplier, w_mplier_next, r_acc_hi, r_acc_lo;
    logic [1:0]       r_cv;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res_hi, r_res_lo;
    logic [3:0]       r_flags, w_flags;
    logic             r_flags_we;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fix_hi, w_fix_lo;
    logic             w_accept, w_last, w_fix_n;

    assign w_op_in  = mul_op_e'(op);
    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;

    // Magnitudes stay WIDTH-bit unsigned so the most-negative value maps to 2^(WIDTH-1).
    assign w_a_mag = (is_signed(w_op_in) && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_b_mag = (is_signed(w_op_in) && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;

    mul_unit_step #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .i_psum (r_psum),
        .i_mcand(r_mcand),
        .i_mbits(r_mplier[BITS_PER_CYCLE-1:0]),
        .o_psum (w_psum_next)
    );

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (w_mplier_next == '0) || (r_cnt == LAST_CNT);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef MUL_EARLY_TERM_EN
                    w_next_state = (w_b_mag == '0) ? ST_FIX : ST_CALC;
`else
                    w_next_state = ST_CALC;
`endif
                end
            end
            ST_CALC: if (w_last) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (flush) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sign fix-up then accumulate, wrapping at the architectural width.
    assign w_prod = r_neg ? (~r_psum + W2'(1)) : r_psum;

    always_comb begin
        w_fix_hi = '0;
        w_fix_lo = '0;
        w_fix_n  = 1'b0;
        if (is_long(r_op)) begin
            {w_fix_hi, w_fix_lo} = w_prod + (is_acc(r_op) ? {r_acc_hi, r_acc_lo} : W2'(0));
            w_fix_n = w_fix_hi[WIDTH-1];
        end else if (is_valid_op(r_op)) begin
            w_fix_lo = w_prod[WIDTH-1:0] + (is_acc(r_op) ? r_acc_lo : WIDTH'(0));
            w_fix_n  = w_fix_lo[WIDTH-1];
        end
    end

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = w_fix_n;
        w_flags[FLAG_Z] = ({w_fix_hi, w_fix_lo} == '0);
        w_flags[FLAG_C] = r_cv[1];
        w_flags[FLAG_V] = r_cv[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= MUL_OP_MUL;
            r_s_bit    <= 1'b0;
            r_neg      <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_psum     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_cv       <= '0;
            r_cnt      <= '0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_flags    <= '0;
            r_flags_we <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_op_in;
                        r_s_bit  <= s_bit;
                        r_neg    <= is_signed(w_op_in) && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_psum   <= '0;
                        r_acc_hi <= acc_hi;
                        r_acc_lo <= acc_lo;
                        r_cv     <= {flags_in[FLAG_C], flags_in[FLAG_V]};
                        r_cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    r_psum   <= w_psum_next;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    r_res_hi   <= w_fix_hi;
                    r_res_lo   <= w_fix_lo;
                    r_flags    <= w_flags;
                    r_flags_we <= r_s_bit && is_valid_op(r_op);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result_hi = r_res_hi;
    assign result_lo = r_res_lo;
    assign flags_out = r_flags;
    assign flags_we  = r_flags_we && out_valid;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed vectors, backpressure, flush and async reset.
module tb_mul_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset, flush, in_valid, in_ready, s_bit;
    logic           out_valid, out_ready, flags_we;
    logic [2:0]     op;
    logic [W-1:0]   a, b, acc_hi, acc_lo, result_hi, result_lo;
    logic [3:0]     flags_in, flags_out;

    mul_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .s_bit(s_bit), .a(a), .b(b),
        .acc_hi(acc_hi), .acc_lo(acc_lo), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_hi(result_hi), .result_lo(result_lo),
        .flags_out(flags_out), .flags_we(flags_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        tag;
        logic [2:0]   op;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [3:0]   fl;
        logic         we;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    logic prev_valid = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: out_valid rose with nothing pending, lo=0x%0h", result_lo);
                end else begin
                    check({sb[0].tag, "_latency"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_hi"}, 64'(result_hi), 64'(e.hi));
                check({e.tag, "_lo"}, 64'(result_lo), 64'(e.lo));
                check({e.tag, "_we"}, 64'(flags_we), 64'(e.we));
                if (e.op != 3'b010 && e.op != 3'b011)
                    check({e.tag, "_flags"}, 64'(flags_out), 64'(e.fl));
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: in_ready still 0 after 200 cycles, expected 1");
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op_i, input logic s_i,
                         input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic [W-1:0] ahi, input logic [W-1:0] alo, input logic [3:0] fl,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic [3:0] efl,
                         input logic ewe, input int lat_early, input bit push);
        exp_t e;
        wait_idle();
        op = op_i; s_bit = s_i; a = a_i; b = b_i;
        acc_hi = ahi; acc_lo = alo; flags_in = fl;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.tag = tag; e.op = op_i; e.hi = ehi; e.lo = elo; e.fl = efl; e.we = ewe;
`ifdef MUL_EARLY_TERM_EN
            e.lat = lat_early;
`else
            e.lat = 33;
`endif
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; s_bit = 1'b0; a = '0; b = '0; acc_hi = '0; acc_lo = '0; flags_in = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flags_we", 64'(flags_we), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);
        check("rst_lo", 64'(result_lo), 64'd0);
        check("rst_flags", 64'(flags_out), 64'd0);
        reset = 1'b0;

        //    tag        op      s  a             b             acc_hi        acc_lo        fl       exp_hi        exp_lo        exp_fl   we  lat
        issue("mul76",   3'b000, 1, 32'd7,        32'd6,        32'd0,        32'd0,        4'b0011, 32'd0,        32'd42,       4'b0011, 1, 4,  1);
        issue("smull_m1x2", 3'b110, 1, 32'hFFFFFFFF, 32'd2,     32'd0,        32'd0,        4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 1, 3,  1);
        issue("smull_min", 3'b110, 1, 32'h80000000, 32'h80000000, 32'd0,      32'd0,        4'b0000, 32'h40000000, 32'd0,        4'b0000, 1, 33, 1);
        issue("umlal_wrap", 3'b101, 1, 32'd1,     32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 32'd0,        32'd0,        4'b0110, 1, 2,  1);
        issue("umlal_max", 3'b101, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,      32'd1,        4'b0001, 32'hFFFFFFFE, 32'd2,        4'b1001, 1, 33, 1);
        issue("mla_wrap",  3'b001, 1, 32'h80000000, 32'd2,      32'h1234,     32'd5,        4'b0000, 32'd0,        32'd5,        4'b0000, 1, 3,  1);
        issue("reserved",  3'b010, 1, 32'd3,      32'd5,        32'd9,        32'd9,        4'b1111, 32'd0,        32'd0,        4'b0000, 0, 4,  1);
        issue("mul_nos",   3'b000, 0, 32'h0000FFFF, 32'h00010001, 32'd0,      32'd0,        4'b0100, 32'd0,        32'hFFFFFFFF, 4'b1000, 0, 18, 1);
        issue("mul3x1",    3'b000, 1, 32'd3,      32'd1,        32'd0,        32'd0,        4'b0000, 32'd0,        32'd3,        4'b0000, 1, 2,  1);
        issue("mul_b0",    3'b000, 1, 32'd5,      32'd0,        32'd0,        32'd0,        4'b0001, 32'd0,        32'd0,        4'b0101, 1, 1,  1);
        issue("smull_nn",  3'b110, 1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0,      32'd0,        4'b0000, 32'd0,        32'd15,       4'b0000, 1, 4,  1);
        issue("smlal",     3'b111, 1, 32'hFFFFFFFF, 32'd1,      32'd0,        32'd2,        4'b0000, 32'd0,        32'd1,        4'b0000, 1, 2,  1);
        issue("umull",     3'b100, 1, 32'hFFFFFFFF, 32'd2,      32'd0,        32'd0,        4'b0000, 32'd1,        32'hFFFFFFFE, 4'b0000, 1, 3,  1);
        wait_drain();

        // Backpressure: result held in DONE while a competing request is offered.
        out_ready = 1'b0;
        issue("bp_mul", 3'b000, 1, 32'd7, 32'd6, 32'd0, 32'd0, 4'b0011, 32'd0, 32'd42, 4'b0011, 1, 4, 1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("bp_reached_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_lo_stable", 64'(result_lo), 64'd42);
            check("bp_hi_stable", 64'(result_hi), 64'd0);
            @(posedge clk);
            #1;
            op = 3'b000; a = 32'd2; b = 32'd2; in_valid = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_after", 64'(in_ready), 64'd1);
        check("bp_valid_drop", 64'(out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Flush mid-CALC drops the operation.
        issue("flushed", 3'b100, 1, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0, 4'b0000, 1, 33, 0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Flush coinciding with a request in IDLE drops the request.
        op = 3'b000; s_bit = 1'b1; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_drop_req", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        issue("post_flush", 3'b000, 1, 32'd7, 32'd6, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd42, 4'b0000, 1, 4, 1);
        wait_drain();

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        issue("reset_op", 3'b100, 1, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0, 4'b0000, 1, 33, 0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_lo", 64'(result_lo), 64'd0);
        check("arst_flags", 64'(flags_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue("post_reset", 3'b001, 1, 32'd4, 32'd5, 32'd0, 32'd2, 4'b0000, 32'd0, 32'd22, 4'b0000, 1, 4, 1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
